dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Sequences and shares the single-ported data memory between two requesters:
//   port 0 = memory pipeline stage, port 1 = debug/program loader.
//   Handles load byte-lane alignment and sign/zero extension, and performs
//   SB/SH as an explicit read-modify-write (read, merge, write).
//   One operation is in flight at a time; requesters stall on req_ready.
// PARAMETERS
//   RR_ARB    1   1 = round-robin between ports; 0 = fixed priority, port 0 wins
// PORTS
//   clk          in   1     clock; all state updates on posedge
//   rst_n        in   1     synchronous reset, active-low
//   req_valid    in   2     per-port request valid
//   req_ready    out  2     per-port accept; transfer when valid & ready
//   req_write    in   2     per-port 1 = store, 0 = load
//   req_funct3   in   2x3   per-port RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr     in   2x32  per-port byte address
//   req_wdata    in   2x32  per-port store data, LSB-aligned
//   resp_valid   out  2     one-cycle pulse to the owning port on completion
//   resp_rdata   out  32    extended load data; 0 for stores and errors
//   resp_err     out  1     qualifies resp_valid: misaligned or illegal funct3
//   mem_en       out  1     memory access strobe
//   mem_we       out  1     1 = write word at mem_addr
//   mem_addr     out  32    word address (byte address with [1:0] = 0)
//   mem_wdata    out  32    full word to write
//   mem_rdata    in   32    read word, valid the cycle after mem_en & !mem_we
//   busy         out  1     1 whenever state != IDLE
// BEHAVIOUR
//   Reset (rst_n low at posedge): state=IDLE, last_grant=1, all outputs 0.
//     While rst_n is low, mem_en, mem_we, req_ready and resp_valid are forced 0.
//     An operation in flight is dropped: no response, no partial write.
//   FSM: IDLE -> RD -> RDWAIT -> (WR) -> RESP -> IDLE; a store word goes
//     IDLE -> WR -> RESP; an error goes IDLE -> RESP.
//   IDLE: req_ready is one-hot to the granted port, and only when that port
//     is valid. Grant with RR_ARB=1: if both ports are valid, grant the port
//     != last_grant; if one is valid, grant it. last_grant updates on accept.
//     On accept, latch port id, write, funct3, addr and wdata.
//   Error check at accept: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0;
//     load funct3 in {011,110,111}; store funct3 > 010.
//     Result: RESP with resp_err=1, no memory access.
//   RD: mem_en=1, mem_we=0, mem_addr={addr[31:2],2'b00}.
//   RDWAIT: sample mem_rdata.
//     Load: shift right by 8*addr[1:0], extend per funct3, register into
//     resp_rdata, go to RESP.
//     SB/SH: merge into a word register. mask = 0xFF (or 0xFFFF) << 8*addr[1:0].
//     merged = (rdata & ~mask) | ((wdata & lane) << 8*addr[1:0]). Go to WR.
//   WR: mem_en=1, mem_we=1. mem_wdata = merged word, or req wdata for SW.
//   RESP: resp_valid[port]=1 for exactly one cycle, then IDLE.
//   Latency, counted in cycles after the accept edge T:
//     SW and errors: resp at T+2 (errors at T+1).
//     Loads: resp at T+3.
//     SB/SH: resp at T+4.
//     The next accept is possible in the cycle after RESP.
//   mem_* outputs are 0 outside RD/WR. resp_rdata holds until the next response.
// TESTING
//   Single-port load:
//     port0 LW 0x10, mem[0x10]=0xDEADBEEF -> resp_valid[0] at T+3,
//     resp_rdata=0xDEADBEEF, err=0.
//   Byte load:
//     LB 0x13, word 0x80FF1234 -> resp_rdata=0xFFFFFF80; LBU -> 0x00000080.
//   Byte store RMW:
//     SB 0x11 data 0xAB over word 0x11223344 -> one read then one write to 0x10
//     of 0x1122AB44; resp at T+4.
//   Round-robin:
//     both ports valid continuously -> grants alternate 0,1,0,1;
//     with RR_ARB=0 -> always port 0.
//   Errors:
//     LW 0x12 and funct3=011 -> resp_err=1 at T+1, mem_en never asserted.
//   Reset mid-op:
//     rst_n low during RDWAIT of an SH -> no WR cycle, no resp_valid,
//     busy=0 and state IDLE after reset.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported data memory between the memory
// pipeline (port 0) and the debug/program loader (port 1). It does load lane
// extraction and extension, and turns SB/SH into a read-merge-write sequence.
// Only one operation is in flight at a time.
module dmem_arbiter #(
  parameter bit RR_ARB = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_write,
  input  logic [1:0][2:0]  req_funct3,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0][31:0] req_wdata,
  output logic [1:0]       resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic             mem_en,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, RD, RDWAIT, WR, RESP} state_e;

  state_e      state_q, state_d;
  logic        lastGrant_q, portId_q, isWrite_q, isErr_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q, merged_q, respRdata_q;

  logic        grantPort, accept, acceptErr;
  logic [4:0]  laneShift;
  logic [31:0] shiftedRdata, loadData, storeLane, laneMask, mergedWord;

  // Misaligned halfword/word accesses and unused funct3 codes are rejected
  function automatic logic isIllegal(input logic write, input logic [2:0] f3,
                                     input logic [1:0] lowAddr);
    logic bad;
    bad = 1'b0;
    if (write) begin
      case (f3)
        3'b000:  bad = 1'b0;
        3'b001:  bad = lowAddr[0];
        3'b010:  bad = (lowAddr != 2'b00);
        default: bad = 1'b1;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b100: bad = 1'b0;
        3'b001, 3'b101: bad = lowAddr[0];
        3'b010:         bad = (lowAddr != 2'b00);
        default:        bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  // Arbitration: round-robin on contention, otherwise whichever port asks
  always_comb begin
    grantPort = req_valid[1];
    if (req_valid == 2'b11) begin
      grantPort = RR_ARB ? ~lastGrant_q : 1'b0;
    end
    accept    = rst_n && (state_q == IDLE) && (req_valid != 2'b00);
    acceptErr = isIllegal(req_write[grantPort], req_funct3[grantPort],
                          req_addr[grantPort][1:0]);
  end

  // Byte-lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    laneShift    = {addr_q[1:0], 3'b000};
    shiftedRdata = mem_rdata >> laneShift;
    case (funct3_q)
      3'b000:  loadData = {{24{shiftedRdata[7]}}, shiftedRdata[7:0]};
      3'b100:  loadData = {24'h000000, shiftedRdata[7:0]};
      3'b001:  loadData = {{16{shiftedRdata[15]}}, shiftedRdata[15:0]};
      3'b101:  loadData = {16'h0000, shiftedRdata[15:0]};
      default: loadData = shiftedRdata;
    endcase
    storeLane  = funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF;
    laneMask   = storeLane << laneShift;
    mergedWord = (mem_rdata & ~laneMask) | ((wdata_q & storeLane) << laneShift);
  end

  // Next-state: errors skip memory, SW skips the read, SB/SH read then write
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (acceptErr) begin
            state_d = RESP;
          end else if (req_write[grantPort] && (req_funct3[grantPort] == 3'b010)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD:      state_d = RDWAIT;
      RDWAIT:  state_d = isWrite_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch at accept, merge word and response data as the op proceeds
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lastGrant_q <= 1'b1;
      portId_q    <= 1'b0;
      isWrite_q   <= 1'b0;
      isErr_q     <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      merged_q    <= 32'h0;
      respRdata_q <= 32'h0;
    end else begin
      if (accept) begin
        lastGrant_q <= grantPort;
        portId_q    <= grantPort;
        isWrite_q   <= req_write[grantPort];
        funct3_q    <= req_funct3[grantPort];
        addr_q      <= req_addr[grantPort];
        wdata_q     <= req_wdata[grantPort];
        isErr_q     <= acceptErr;
        if (acceptErr) begin
          respRdata_q <= 32'h0;
        end
      end
      if (state_q == RDWAIT) begin
        if (isWrite_q) begin
          merged_q <= mergedWord;
        end else begin
          respRdata_q <= loadData;
        end
      end
      if (state_q == WR) begin
        respRdata_q <= 32'h0;
      end
    end
  end

  // Outputs; handshakes and memory strobes are held off while reset is low
  always_comb begin
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    resp_err   = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    if (accept) begin
      req_ready = grantPort ? 2'b10 : 2'b01;
    end
    if (rst_n && (state_q == RESP)) begin
      resp_valid = portId_q ? 2'b10 : 2'b01;
      resp_err   = isErr_q;
    end
    if (state_q == RD || state_q == WR) begin
      mem_addr = {addr_q[31:2], 2'b00};
      mem_en   = rst_n;
    end
    if (state_q == WR) begin
      mem_we    = rst_n;
      mem_wdata = (funct3_q == 3'b010) ? wdata_q : merged_q;
    end
  end

  assign resp_rdata = respRdata_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors for dmem_arbiter against a small word
// memory model, plus hand sequences for reset, mid-op reset and arbitration.
module tb_dmem_arbiter;

  typedef struct {
    logic        port;
    logic        write;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memInit;
    logic [31:0] expRdata;
    logic        expErr;
    int          expLat;
    logic [31:0] expMem;
    int          expReads;
    int          expWrites;
  } vec_t;

  localparam int NV = 17;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_write;
  logic [1:0][2:0]  req_funct3;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       resp_valid;
  logic [31:0]      resp_rdata;
  logic             resp_err;
  logic             mem_en;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;
  logic             busy;

  logic [1:0]       fxReady, fxRespValid;
  logic [31:0]      fxRespRdata, fxMemAddr, fxMemWdata;
  logic             fxRespErr, fxMemEn, fxMemWe, fxBusy;

  logic [31:0]      mem [0:255];
  logic             preloadEn;
  logic [7:0]       preloadIdx;
  logic [31:0]      preloadData;
  int               rdCount = 0;
  int               wrCount = 0;
  int               respCount = 0;

  int               testsRun = 0;
  int               failed = 0;
  vec_t             vecs [NV];

  dmem_arbiter #(.RR_ARB(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_arbiter #(.RR_ARB(1'b0)) dutFixed (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(fxReady), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(fxRespValid), .resp_rdata(fxRespRdata), .resp_err(fxRespErr),
    .mem_en(fxMemEn), .mem_we(fxMemWe), .mem_addr(fxMemAddr),
    .mem_wdata(fxMemWdata), .mem_rdata(32'h0), .busy(fxBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory model with one-cycle read latency and access counters
  always @(posedge clk) begin
    if (preloadEn) mem[preloadIdx] <= preloadData;
    if (mem_en && !mem_we) begin
      mem_rdata <= mem[mem_addr[9:2]];
      rdCount   <= rdCount + 1;
    end
    if (mem_en && mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      wrCount            <= wrCount + 1;
    end
    if (resp_valid != 2'b00) respCount <= respCount + 1;
  end

  function automatic vec_t mk(input logic p, input logic w, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] init, input logic [31:0] expR,
                              input logic e, input int lat, input logic [31:0] expM,
                              input int r, input int wc);
    vec_t v;
    v.port = p; v.write = w; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.memInit = init; v.expRdata = expR; v.expErr = e; v.expLat = lat;
    v.expMem = expM; v.expReads = r; v.expWrites = wc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, output int lat, output logic [1:0] rv,
                               output logic [31:0] rdata, output logic err,
                               output logic accepted, output logic [1:0] rvAfter,
                               output logic busyAfter, output int rdDelta,
                               output int wrDelta, output logic [31:0] memAfter);
    int rd0, wr0, waitCnt;
    @(negedge clk);
    preloadEn = 1'b1; preloadIdx = v.addr[9:2]; preloadData = v.memInit;
    @(negedge clk);
    preloadEn = 1'b0;
    rd0 = rdCount; wr0 = wrCount;
    req_valid = 2'b00;
    req_valid[v.port]  = 1'b1;
    req_write[v.port]  = v.write;
    req_funct3[v.port] = v.f3;
    req_addr[v.port]   = v.addr;
    req_wdata[v.port]  = v.wdata;
    #1;
    waitCnt = 0;
    while (!req_ready[v.port] && waitCnt < 20) begin
      @(negedge clk); #1;
      waitCnt++;
    end
    accepted = req_ready[v.port];
    @(posedge clk); #1;
    req_valid = 2'b00;
    lat = -1; rv = 2'b00; rdata = 32'h0; err = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) begin
        lat = c; rv = resp_valid; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
    @(negedge clk);
    rvAfter   = resp_valid;
    busyAfter = busy;
    rdDelta   = rdCount - rd0;
    wrDelta   = wrCount - wr0;
    memAfter  = mem[v.addr[9:2]];
  endtask

  // Watchdog so a stuck design still ends the run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat, rdD, wrD, grants, wr0, resp0;
    logic [1:0]  rv, rvAfter;
    logic [31:0] rdata, memAfter;
    logic        err, accepted, busyAfter;
    int          grantCyc [4];
    string       nm;

    vecs[0]  = mk(0, 0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0, 3, 32'hDEADBEEF, 1, 0);
    vecs[1]  = mk(0, 0, 3'b000, 32'h13, 32'h0,        32'h80FF1234, 32'hFFFFFF80, 0, 3, 32'h80FF1234, 1, 0);
    vecs[2]  = mk(0, 0, 3'b100, 32'h13, 32'h0,        32'h80FF1234, 32'h00000080, 0, 3, 32'h80FF1234, 1, 0);
    vecs[3]  = mk(0, 0, 3'b001, 32'h12, 32'h0,        32'h80FF1234, 32'hFFFF80FF, 0, 3, 32'h80FF1234, 1, 0);
    vecs[4]  = mk(0, 0, 3'b101, 32'h12, 32'h0,        32'h80FF1234, 32'h000080FF, 0, 3, 32'h80FF1234, 1, 0);
    vecs[5]  = mk(1, 0, 3'b000, 32'h21, 32'h0,        32'h11223344, 32'h00000033, 0, 3, 32'h11223344, 1, 0);
    vecs[6]  = mk(0, 0, 3'b010, 32'h12, 32'h0,        32'h01010101, 32'h00000000, 1, 1, 32'h01010101, 0, 0);
    vecs[7]  = mk(0, 1, 3'b000, 32'h11, 32'hFFFFFFAB, 32'h11223344, 32'h00000000, 0, 4, 32'h1122AB44, 1, 1);
    vecs[8]  = mk(1, 1, 3'b001, 32'h16, 32'h1234BEEF, 32'h11223344, 32'h00000000, 0, 4, 32'hBEEF3344, 1, 1);
    vecs[9]  = mk(0, 1, 3'b010, 32'h18, 32'hCAFEF00D, 32'h55555555, 32'h00000000, 0, 2, 32'hCAFEF00D, 0, 1);
    vecs[10] = mk(0, 0, 3'b001, 32'h10, 32'h0,        32'h00008001, 32'hFFFF8001, 0, 3, 32'h00008001, 1, 0);
    vecs[11] = mk(0, 0, 3'b011, 32'h10, 32'h0,        32'h01010101, 32'h00000000, 1, 1, 32'h01010101, 0, 0);
    vecs[12] = mk(0, 1, 3'b001, 32'h13, 32'h0000AAAA, 32'h77777777, 32'h00000000, 1, 1, 32'h77777777, 0, 0);
    vecs[13] = mk(1, 1, 3'b011, 32'h20, 32'h12345678, 32'h66666666, 32'h00000000, 1, 1, 32'h66666666, 0, 0);
    vecs[14] = mk(1, 0, 3'b010, 32'h24, 32'h0,        32'h01234567, 32'h01234567, 0, 3, 32'h01234567, 1, 0);
    vecs[15] = mk(0, 0, 3'b110, 32'h20, 32'h0,        32'h66666666, 32'h00000000, 1, 1, 32'h66666666, 0, 0);
    vecs[16] = mk(0, 1, 3'b000, 32'h1B, 32'h0000005A, 32'hFFFFFFFF, 32'h00000000, 0, 4, 32'h5AFFFFFF, 1, 1);

    rst_n = 1'b0; req_valid = 2'b11; req_write = 2'b00;
    req_funct3 = '0; req_addr = '0; req_wdata = '0;
    preloadEn = 1'b0; preloadIdx = 8'h0; preloadData = 32'h0;

    // Reset state, with both ports requesting to show ready stays low
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst.req_ready", 32'(req_ready), 32'h0);
    checkOutput("rst.resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("rst.mem_en", 32'(mem_en), 32'h0);
    checkOutput("rst.mem_we", 32'(mem_we), 32'h0);
    checkOutput("rst.busy", 32'(busy), 32'h0);
    checkOutput("rst.resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst.resp_err", 32'(resp_err), 32'h0);
    req_valid = 2'b00;
    rst_n = 1'b1;

    // Directed single transactions
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i], lat, rv, rdata, err, accepted, rvAfter, busyAfter,
                    rdD, wrD, memAfter);
      nm = $sformatf("v%0d", i);
      checkOutput({nm, ".accept"}, 32'(accepted), 32'h1);
      checkOutput({nm, ".latency"}, 32'(lat), 32'(vecs[i].expLat));
      checkOutput({nm, ".resp_port"}, 32'(rv), 32'(2'b01 << vecs[i].port));
      checkOutput({nm, ".rdata"}, rdata, vecs[i].expRdata);
      checkOutput({nm, ".err"}, 32'(err), 32'(vecs[i].expErr));
      checkOutput({nm, ".pulse_end"}, 32'(rvAfter), 32'h0);
      checkOutput({nm, ".busy_after"}, 32'(busyAfter), 32'h0);
      checkOutput({nm, ".mem_reads"}, 32'(rdD), 32'(vecs[i].expReads));
      checkOutput({nm, ".mem_writes"}, 32'(wrD), 32'(vecs[i].expWrites));
      checkOutput({nm, ".mem_word"}, memAfter, vecs[i].expMem);
    end

    // Reset while an SH is waiting on its read: no write, no response
    @(negedge clk);
    preloadEn = 1'b1; preloadIdx = 8'h0C; preloadData = 32'h11223344;
    @(negedge clk);
    preloadEn = 1'b0;
    req_valid = 2'b01; req_write[0] = 1'b1; req_funct3[0] = 3'b001;
    req_addr[0] = 32'h32; req_wdata[0] = 32'h00005566;
    #1;
    checkOutput("midrst.ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wr0 = wrCount; resp0 = respCount;
    @(negedge clk);
    checkOutput("midrst.rd_strobe", 32'(mem_en), 32'h1);
    @(negedge clk);
    checkOutput("midrst.busy_rdwait", 32'(busy), 32'h1);
    rst_n = 1'b0; req_valid = 2'b11;
    #1;
    checkOutput("midrst.ready_low", 32'(req_ready), 32'h0);
    @(negedge clk);
    checkOutput("midrst.busy_cleared", 32'(busy), 32'h0);
    checkOutput("midrst.ready_forced", 32'(req_ready), 32'h0);
    checkOutput("midrst.mem_en_low", 32'(mem_en), 32'h0);
    req_valid = 2'b00; rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("midrst.no_write", 32'(wrCount - wr0), 32'h0);
    checkOutput("midrst.no_resp", 32'(respCount - resp0), 32'h0);
    checkOutput("midrst.mem_kept", mem[8'h0C], 32'h11223344);
    checkOutput("midrst.busy_idle", 32'(busy), 32'h0);
    checkOutput("midrst.rdata_zero", resp_rdata, 32'h0);

    // Both ports loading continuously: grants alternate starting at port 0
    @(negedge clk);
    req_write = 2'b00; req_funct3[0] = 3'b010; req_funct3[1] = 3'b010;
    req_addr[0] = 32'h40; req_addr[1] = 32'h44;
    req_valid = 2'b11;
    grants = 0;
    for (int c = 0; c < 60 && grants < 4; c++) begin
      #1;
      if (!busy && req_ready != 2'b00) begin
        checkOutput($sformatf("rr.grant%0d", grants), 32'(req_ready),
                    (grants % 2 == 0) ? 32'h1 : 32'h2);
        grantCyc[grants] = c;
        grants++;
      end
      if (!fxBusy) begin
        checkOutput($sformatf("fixed.ready_c%0d", c), 32'(fxReady), 32'h1);
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    checkOutput("rr.grant_count", 32'(grants), 32'h4);
    for (int k = 0; k < 3; k++) begin
      if (k + 1 < grants) begin
        checkOutput($sformatf("rr.spacing%0d", k), 32'(grantCyc[k+1] - grantCyc[k]), 32'h4);
      end
    end
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, failed);
    $finish;
  end

endmodule
